// File: rtl/mcpu_ctrl_pkg.sv
// Shared ALU operation codes and MCPU control encodings.
// State, opcode, funct and datapath select constants.
package alu_define;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LU   = 4'd11;
  localparam logic [3:0] ALU_BNE  = 4'd12;
  localparam logic [3:0] ALU_BLEZ = 4'd13;
  localparam logic [3:0] ALU_BGTZ = 4'd14;
  localparam logic [3:0] ALU_BLTZ = 4'd15;

endpackage

package mcpu_ctrl_define;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXE    = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXE    = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JUMP_R   = 4'd12,
    S_ILLEGAL  = 4'd13
  } state_t;

  localparam state_t RESET_STATE = S_FETCH;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MDR = 2'd1;
  localparam logic [1:0] M2R_PC  = 2'd2;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_A     = 2'd1;
  localparam logic [1:0] SRCA_SHAMT = 2'd2;

  localparam logic [1:0] SRCB_B    = 2'd0;
  localparam logic [1:0] SRCB_4    = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;
  localparam logic [1:0] SRCB_BOFF = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_REG    = 2'd3;

endpackage

// File: rtl/mcpu_alu_dec.sv
// ALU control decode: state/op/funct/rt to ALUOp, ExtSel,
// ALUSrcA and a per-state illegal-instruction flag.
module mcpu_alu_dec
  import alu_define::*;
  import mcpu_ctrl_define::*;
(
  input  logic [3:0] state,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  output logic [3:0] alu_op,
  output logic       ext_sel,
  output logic [1:0] alu_src_a,
  output logic       dec_illegal
);

  state_t     st;
  logic [3:0] r_op;
  logic       r_ok;
  logic       r_shamt;
  logic [3:0] i_op;
  logic       i_ext;
  logic [3:0] b_op;
  logic       b_ok;

  assign st = state_t'(state);

  always_comb begin
    r_op    = ALU_ADD;
    r_ok    = 1'b1;
    r_shamt = 1'b0;
    case (funct)
      F_ADD, F_ADDU: r_op = ALU_ADD;
      F_SUB, F_SUBU: r_op = ALU_SUB;
      F_AND:         r_op = ALU_AND;
      F_OR:          r_op = ALU_OR;
      F_XOR:         r_op = ALU_XOR;
      F_NOR:         r_op = ALU_NOR;
      F_SLT:         r_op = ALU_SLT;
      F_SLTU:        r_op = ALU_SLTU;
      F_SLL: begin
        r_op    = ALU_SLL;
        r_shamt = 1'b1;
      end
      F_SRL: begin
        r_op    = ALU_SRL;
        r_shamt = 1'b1;
      end
      F_SRA: begin
        r_op    = ALU_SRA;
        r_shamt = 1'b1;
      end
      F_SLLV:        r_op = ALU_SLL;
      F_SRLV:        r_op = ALU_SRL;
      F_SRAV:        r_op = ALU_SRA;
      default:       r_ok = 1'b0;
    endcase
  end

  always_comb begin
    i_op  = ALU_ADD;
    i_ext = 1'b0;
    case (op)
      OP_SLTI:  i_op = ALU_SLT;
      OP_SLTIU: i_op = ALU_SLTU;
      OP_ANDI: begin
        i_op  = ALU_AND;
        i_ext = 1'b1;
      end
      OP_ORI: begin
        i_op  = ALU_OR;
        i_ext = 1'b1;
      end
      OP_XORI: begin
        i_op  = ALU_XOR;
        i_ext = 1'b1;
      end
      OP_LUI: begin
        i_op  = ALU_LU;
        i_ext = 1'b1;
      end
      default: i_op = ALU_ADD;
    endcase
  end

  // Branch codes are chosen so the ALU raises Zero exactly when taken.
  always_comb begin
    b_op = ALU_SUB;
    b_ok = 1'b1;
    case (op)
      OP_BEQ:    b_op = ALU_SUB;
      OP_BNE:    b_op = ALU_BNE;
      OP_BLEZ:   b_op = ALU_BGTZ;
      OP_BGTZ:   b_op = ALU_BLEZ;
      OP_REGIMM: begin
        b_op = ALU_BLTZ;
        b_ok = (rt == 5'd0) || (rt == 5'd1);
      end
      default:   b_ok = 1'b0;
    endcase
  end

  always_comb begin
    alu_op      = ALU_ADD;
    ext_sel     = 1'b0;
    alu_src_a   = SRCA_PC;
    dec_illegal = 1'b0;
    case (st)
      S_MEM_ADDR: alu_src_a = SRCA_A;
      S_R_EXE: begin
        alu_op      = r_op;
        alu_src_a   = r_shamt ? SRCA_SHAMT : SRCA_A;
        dec_illegal = !r_ok;
      end
      S_I_EXE: begin
        alu_op    = i_op;
        ext_sel   = i_ext;
        alu_src_a = SRCA_A;
      end
      S_BRANCH: begin
        alu_op      = b_op;
        alu_src_a   = SRCA_A;
        dec_illegal = !b_ok;
      end
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mcpu_ctrl.sv
// Multi-cycle MCPU control FSM: fetch, decode, execute,
// memory and writeback sequencing for the shared datapath.
module mcpu_ctrl
  import alu_define::*;
  import mcpu_ctrl_define::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ExtSel,
  output logic [1:0] PCSource,
  output logic [3:0] ALUOp,
  output logic       illegal
);

  state_t     state;
  state_t     state_n;
  logic [3:0] dec_op;
  logic       dec_ext;
  logic [1:0] dec_src_a;
  logic       dec_ill;
  logic       is_mem;
  logic       is_r;
  logic       is_jr;
  logic       is_imm;
  logic       is_br;
  logic       is_j;

  mcpu_alu_dec u_alu_dec (
    .state       (state),
    .op          (op),
    .funct       (funct),
    .rt          (rt),
    .alu_op      (dec_op),
    .ext_sel     (dec_ext),
    .alu_src_a   (dec_src_a),
    .dec_illegal (dec_ill)
  );

  // Zero is consumed by the PC write qualifier in the datapath.
  logic unused_zero;
  assign unused_zero = Zero;

  assign is_mem = (op == OP_LW) || (op == OP_SW);
  assign is_jr  = (op == OP_RTYPE) && (funct == F_JR);
  assign is_r   = (op == OP_RTYPE) && !is_jr;
  assign is_imm = (op >= OP_ADDI) && (op <= OP_LUI);
  assign is_br  = (op == OP_REGIMM) ||
                  ((op >= OP_BEQ) && (op <= OP_BGTZ));
  assign is_j   = (op == OP_J) || (op == OP_JAL);

  always_comb begin
    state_n = state;
    unique case (state)
      S_FETCH:    if (mem_ready) state_n = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_mem:  state_n = S_MEM_ADDR;
          is_r:    state_n = S_R_EXE;
          is_jr:   state_n = S_JUMP_R;
          is_imm:  state_n = S_I_EXE;
          is_br:   state_n = S_BRANCH;
          is_j:    state_n = S_JUMP;
          default: state_n = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR:
        state_n = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_n = S_MEM_WB;
      S_MEM_WB:   state_n = S_FETCH;
      S_MEM_WR:   if (mem_ready) state_n = S_FETCH;
      S_R_EXE:    state_n = dec_ill ? S_ILLEGAL : S_R_WB;
      S_R_WB:     state_n = S_FETCH;
      S_I_EXE:    state_n = S_I_WB;
      S_I_WB:     state_n = S_FETCH;
      S_BRANCH:   state_n = dec_ill ? S_ILLEGAL : S_FETCH;
      S_JUMP:     state_n = S_FETCH;
      S_JUMP_R:   state_n = S_FETCH;
      S_ILLEGAL:  state_n = S_ILLEGAL;
      default:    state_n = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RESET_STATE;
    else        state <= state_n;
  end

  // All outputs collapse to the idle vector while rst_n is low.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = REGDST_RT;
    MemtoReg    = M2R_ALU;
    RegWrite    = 1'b0;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_B;
    ExtSel      = 1'b0;
    PCSource    = PCSRC_ALU;
    ALUOp       = ALU_ADD;
    illegal     = 1'b0;
    if (rst_n) begin
      ALUOp   = dec_op;
      ExtSel  = dec_ext;
      ALUSrcA = dec_src_a;
      case (state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_4;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE:   ALUSrcB = SRCB_BOFF;
        S_MEM_ADDR: ALUSrcB = SRCB_IMM;
        S_MEM_RD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEM_WB: begin
          RegWrite = 1'b1;
          MemtoReg = M2R_MDR;
        end
        S_MEM_WR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_R_EXE:    ALUSrcB = SRCB_B;
        S_R_WB: begin
          RegWrite = 1'b1;
          RegDst   = REGDST_RD;
        end
        S_I_EXE:    ALUSrcB = SRCB_IMM;
        S_I_WB:     RegWrite = 1'b1;
        S_BRANCH: begin
          PCWriteCond = !dec_ill;
          PCSource    = PCSRC_ALUOUT;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = PCSRC_JUMP;
          if (op == OP_JAL) begin
            RegWrite = 1'b1;
            RegDst   = REGDST_RA;
            MemtoReg = M2R_PC;
          end
        end
        S_JUMP_R: begin
          PCWrite  = 1'b1;
          PCSource = PCSRC_REG;
        end
        S_ILLEGAL:  illegal = 1'b1;
        default:    illegal = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Directed scoreboard bench for mcpu_ctrl: expected per-cycle
// control vectors are queued by the driver and checked by a monitor.
module tb_mcpu_ctrl;
  import alu_define::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rt;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
  logic       IRWrite, RegWrite, ExtSel, illegal;
  logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
  logic [3:0] ALUOp;

  typedef struct packed {
    logic       pcw;
    logic       pcwc;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic [1:0] rdst;
    logic [1:0] m2r;
    logic       rw;
    logic [1:0] sa;
    logic [1:0] sb;
    logic       ext;
    logic [1:0] pcs;
    logic [3:0] aop;
    logic       ill;
  } ov_t;

  typedef struct {
    ov_t   v;
    ov_t   m;
    string tag;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  ov_t  got;

  mcpu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .rt(rt),
    .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel),
    .PCSource(PCSource), .ALUOp(ALUOp), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign got = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
                IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                ALUSrcB, ExtSel, PCSource, ALUOp, illegal};

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if ((got & e.m) !== (e.v & e.m)) begin
        bad++;
        $display("FAIL %s: got=%h want=%h mask=%h",
                 e.tag, got, e.v, e.m);
      end
    end
  end

  function automatic exp_t base(string t);
    exp_t e;
    e.tag = t;
    e.v = '0;
    e.m = '0;
    e.m.pcw = 1'b1; e.m.pcwc = 1'b1; e.m.mrd = 1'b1;
    e.m.mwr = 1'b1; e.m.irw = 1'b1; e.m.rw = 1'b1;
    e.m.ill = 1'b1;
    return e;
  endfunction

  function automatic exp_t x_rst();
    exp_t e = base("RESET");
    e.m = '1;
    e.v.aop = ALU_ADD;
    return e;
  endfunction

  function automatic exp_t x_fetch(logic rdy);
    exp_t e = base("FETCH");
    e.v.mrd = 1'b1; e.v.irw = rdy; e.v.pcw = rdy;
    e.v.iord = 1'b0; e.m.iord = 1'b1;
    e.v.sa = 2'd0; e.m.sa = '1;
    e.v.sb = 2'd1; e.m.sb = '1;
    e.v.aop = ALU_ADD; e.m.aop = '1;
    e.v.pcs = 2'd0; e.m.pcs = '1;
    return e;
  endfunction

  function automatic exp_t x_decode();
    exp_t e = base("DECODE");
    e.v.sa = 2'd0; e.m.sa = '1;
    e.v.sb = 2'd3; e.m.sb = '1;
    e.v.aop = ALU_ADD; e.m.aop = '1;
    return e;
  endfunction

  function automatic exp_t x_maddr();
    exp_t e = base("MEM_ADDR");
    e.v.sa = 2'd1; e.m.sa = '1;
    e.v.sb = 2'd2; e.m.sb = '1;
    e.v.ext = 1'b0; e.m.ext = 1'b1;
    e.v.aop = ALU_ADD; e.m.aop = '1;
    return e;
  endfunction

  function automatic exp_t x_mrd();
    exp_t e = base("MEM_RD");
    e.v.mrd = 1'b1;
    e.v.iord = 1'b1; e.m.iord = 1'b1;
    return e;
  endfunction

  function automatic exp_t x_mwr();
    exp_t e = base("MEM_WR");
    e.v.mwr = 1'b1;
    e.v.iord = 1'b1; e.m.iord = 1'b1;
    return e;
  endfunction

  function automatic exp_t x_wb(string t, logic [1:0] rd,
                                logic [1:0] m2);
    exp_t e = base(t);
    e.v.rw = 1'b1;
    e.v.rdst = rd; e.m.rdst = '1;
    e.v.m2r = m2; e.m.m2r = '1;
    return e;
  endfunction

  function automatic exp_t x_rexe(logic [3:0] a, logic [1:0] s);
    exp_t e = base("R_EXE");
    e.v.sb = 2'd0; e.m.sb = '1;
    e.v.sa = s; e.m.sa = '1;
    e.v.aop = a; e.m.aop = '1;
    return e;
  endfunction

  function automatic exp_t x_iexe(logic [3:0] a, logic x,
                                  logic chk);
    exp_t e = base("I_EXE");
    e.v.sa = 2'd1; e.m.sa = '1;
    e.v.sb = 2'd2; e.m.sb = '1;
    e.v.aop = a; e.m.aop = '1;
    e.v.ext = x; e.m.ext = chk;
    return e;
  endfunction

  function automatic exp_t x_br(logic [3:0] a);
    exp_t e = base("BRANCH");
    e.v.pcwc = 1'b1;
    e.v.sa = 2'd1; e.m.sa = '1;
    e.v.sb = 2'd0; e.m.sb = '1;
    e.v.pcs = 2'd1; e.m.pcs = '1;
    e.v.aop = a; e.m.aop = '1;
    return e;
  endfunction

  function automatic exp_t x_jump(logic jal);
    exp_t e = base(jal ? "JAL" : "J");
    e.v.pcw = 1'b1;
    e.v.pcs = 2'd2; e.m.pcs = '1;
    if (jal) begin
      e.v.rw = 1'b1;
      e.v.rdst = 2'd2; e.m.rdst = '1;
      e.v.m2r = 2'd2; e.m.m2r = '1;
    end
    return e;
  endfunction

  function automatic exp_t x_jr();
    exp_t e = base("JUMP_R");
    e.v.pcw = 1'b1;
    e.v.pcs = 2'd3; e.m.pcs = '1;
    return e;
  endfunction

  function automatic exp_t x_ill();
    exp_t e = base("ILLEGAL");
    e.v.ill = 1'b1;
    return e;
  endfunction

  task automatic step(input exp_t e);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic ir(input logic [5:0] o, input logic [5:0] f,
                    input logic [4:0] r);
    op = o;
    funct = f;
    rt = r;
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; Zero = 1'b0;
    ir(6'h00, 6'h00, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    step(x_rst());
    step(x_rst());
    rst_n = 1'b1;
    mem_ready = 1'b1;

    // ADD r3,r1,r2
    ir(6'h00, 6'h20, 5'd2);
    step(x_fetch(1'b1));
    step(x_decode());
    step(x_rexe(ALU_ADD, 2'd1));
    step(x_wb("R_WB", 2'd1, 2'd0));

    // LW with three wait cycles in MEM_RD
    ir(6'h23, 6'h04, 5'd5);
    step(x_fetch(1'b1));
    step(x_decode());
    step(x_maddr());
    mem_ready = 1'b0;
    repeat (3) step(x_mrd());
    mem_ready = 1'b1;
    step(x_mrd());
    step(x_wb("MEM_WB", 2'd0, 2'd1));

    // BNE taken then not taken
    ir(6'h05, 6'h10, 5'd3);
    Zero = 1'b1;
    step(x_fetch(1'b1));
    step(x_decode());
    step(x_br(ALU_BNE));
    Zero = 1'b0;
    step(x_fetch(1'b1));
    step(x_decode());
    step(x_br(ALU_BNE));

    // BEQ after a fetch wait cycle
    ir(6'h04, 6'h00, 5'd1);
    mem_ready = 1'b0;
    step(x_fetch(1'b0));
    mem_ready = 1'b1;
    step(x_fetch(1'b1));
    step(x_decode());
    step(x_br(ALU_SUB));

    // BLEZ and BGTZ use the swapped ALU codes
    ir(6'h06, 6'h00, 5'd0);
    step(x_fetch(1'b1));
    step(x_decode());
    step(x_br(ALU_BGTZ));
    ir(6'h07, 6'h00, 5'd0);
    step(x_fetch(1'b1));
    step(x_decode());
    step(x_br(ALU_BLEZ));

    // REGIMM rt=01
    ir(6'h01, 6'h00, 5'd1);
    step(x_fetch(1'b1));
    step(x_decode());
    step(x_br(ALU_BLTZ));

    // SLL and SRLV
    ir(6'h00, 6'h00, 5'd4);
    step(x_fetch(1'b1));
    step(x_decode());
    step(x_rexe(ALU_SLL, 2'd2));
    step(x_wb("R_WB", 2'd1, 2'd0));
    ir(6'h00, 6'h06, 5'd4);
    step(x_fetch(1'b1));
    step(x_decode());
    step(x_rexe(ALU_SRL, 2'd1));
    step(x_wb("R_WB", 2'd1, 2'd0));

    // ORI, SLTI, LUI
    ir(6'h0D, 6'h3F, 5'd7);
    step(x_fetch(1'b1));
    step(x_decode());
    step(x_iexe(ALU_OR, 1'b1, 1'b1));
    step(x_wb("I_WB", 2'd0, 2'd0));
    ir(6'h0A, 6'h00, 5'd7);
    step(x_fetch(1'b1));
    step(x_decode());
    step(x_iexe(ALU_SLT, 1'b0, 1'b1));
    step(x_wb("I_WB", 2'd0, 2'd0));
    ir(6'h0F, 6'h00, 5'd7);
    step(x_fetch(1'b1));
    step(x_decode());
    step(x_iexe(ALU_LU, 1'b0, 1'b0));
    step(x_wb("I_WB", 2'd0, 2'd0));

    // JAL, J, JR
    ir(6'h03, 6'h00, 5'd0);
    step(x_fetch(1'b1));
    step(x_decode());
    step(x_jump(1'b1));
    ir(6'h02, 6'h00, 5'd0);
    step(x_fetch(1'b1));
    step(x_decode());
    step(x_jump(1'b0));
    ir(6'h00, 6'h08, 5'd0);
    step(x_fetch(1'b1));
    step(x_decode());
    step(x_jr());

    // SW, then reset while waiting in MEM_WR
    ir(6'h2B, 6'h00, 5'd2);
    step(x_fetch(1'b1));
    step(x_decode());
    step(x_maddr());
    mem_ready = 1'b0;
    step(x_mwr());
    rst_n = 1'b0;
    step(x_rst());
    rst_n = 1'b1;
    mem_ready = 1'b1;
    ir(6'h00, 6'h21, 5'd2);
    step(x_fetch(1'b1));
    step(x_decode());
    step(x_rexe(ALU_ADD, 2'd1));
    step(x_wb("R_WB", 2'd1, 2'd0));

    // Unsupported funct 01 traps after R_EXE
    ir(6'h00, 6'h01, 5'd0);
    step(x_fetch(1'b1));
    step(x_decode());
    q.push_back(base("R_EXE_BAD"));
    @(posedge clk);
    #1;
    repeat (3) step(x_ill());

    // Unsupported opcode 3F traps straight from DECODE
    rst_n = 1'b0;
    step(x_rst());
    rst_n = 1'b1;
    ir(6'h3F, 6'h20, 5'd0);
    step(x_fetch(1'b1));
    step(x_decode());
    repeat (2) step(x_ill());
    mem_ready = 1'b0;
    step(x_ill());

    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mcpu_ctrl.md
Name: mcpu_ctrl

Overview:
- Multi-cycle control FSM for the MCPU: sequences fetch/decode/execute/memory/writeback.
- Drives every datapath mux select and write enable, and the 4-bit ALUOp of the shared ALU.
- Takes opcode/funct/rt from the instruction register, Zero from the ALU, and a ready handshake from unified memory.
- Branch decisions rely on ALU codes producing Zero=1 exactly when the branch is taken.

Parameters:
- RESET_STATE, FETCH, state entered on reset.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- op  in  6  IR[31:26], stable from cycle after IRWrite
- funct  in  6  IR[5:0]
- rt  in  5  IR[20:16] (REGIMM decode)
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current MemRead/MemWrite this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load qualified by Zero
- IorD  out  1  0=PC, 1=ALUOut drives memory address
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  latch instruction
- RegDst  out  2  0=rt, 1=rd, 2=r31
- MemtoReg  out  2  0=ALUOut, 1=MDR, 2=PC
- RegWrite  out  1  register file write
- ALUSrcA  out  2  0=PC, 1=A(rs), 2=zero-extended shamt
- ALUSrcB  out  2  0=B(rt), 1=const 4, 2=ext imm, 3=sign-ext imm<<2
- ExtSel  out  1  0=sign-, 1=zero-extend imm
- PCSource  out  2  0=ALU result, 1=ALUOut, 2=jump target, 3=A
- ALUOp  out  4  ALU operation code (shared alu_define constants)
- illegal  out  1  unsupported instruction trapped; sticky until reset

Behaviour:
- One clock, clk. Reset synchronous, active-low, on rst_n: state<=FETCH, illegal<=0. While rst_n=0, all enables (PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite) forced 0, ALUOp=ADD, all selects 0. Reset mid-instruction aborts with no further writes.
- Moore outputs decoded from state plus op/funct/rt (stable after FETCH).
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=ADD, PCSource=0. Holds until mem_ready. In the mem_ready cycle, IRWrite=1 and PCWrite=1, then go to DECODE. No writes while waiting.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=ADD (branch target into ALUOut). Dispatch on op:
  - LW/SW -> MEM_ADDR
  - R-type -> R_EXE, except JR -> JUMP_R
  - ALU-imm -> I_EXE
  - BEQ/BNE/BLEZ/BGTZ/REGIMM -> BRANCH
  - J/JAL -> JUMP
  - anything else -> ILLEGAL
- MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ExtSel=0, ALUOp=ADD. Next MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: MemRead=1, IorD=1, holds until mem_ready, then MEM_WB.
- MEM_WB: RegWrite=1, RegDst=0, MemtoReg=1, then FETCH.
- MEM_WR: MemWrite=1, IorD=1, holds until mem_ready, then FETCH.
- R_EXE: ALUSrcB=0. ALUSrcA=2 for SLL/SRL/SRA (funct 00/02/03), else 1. funct->ALUOp: 20/21 ADD, 22/23 SUB, 24 AND, 25 OR, 26 XOR, 27 NOR, 2A SLT, 2B SLTU, 00/04 SLL, 02/06 SRL, 03/07 SRA. Other funct -> ILLEGAL, no write. Next R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=0, then FETCH.
- I_EXE: ALUSrcA=1, ALUSrcB=2. Op->ALUOp and ExtSel:
  - 08/09 ADD, ExtSel=0
  - 0A SLT, ExtSel=0
  - 0B SLTU, ExtSel=0
  - 0C AND, ExtSel=1
  - 0D OR, ExtSel=1
  - 0E XOR, ExtSel=1
  - 0F LU
  Next I_WB.
- I_WB: RegWrite=1, RegDst=0, MemtoReg=0, then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, PCWriteCond=1, PCSource=1. ALUOp: BEQ SUB, BNE BNE, BLEZ BGTZ, BGTZ BLEZ, REGIMM(rt=00/01) BLTZ. REGIMM with other rt -> ILLEGAL. Taken iff Zero=1. Then FETCH.
- JUMP: PCWrite=1, PCSource=2. JAL additionally RegWrite=1, RegDst=2, MemtoReg=2 (PC already +4). Then FETCH.
- JUMP_R: PCWrite=1, PCSource=3, then FETCH.
- ILLEGAL: illegal=1, all enables 0, terminal until reset.
- Latency with mem_ready=1 on first request:
  - R/imm/LW-free writes: 4 cycles
  - LW: 5
  - SW: 4
  - branch, J, JR: 3
- Each mem_ready stall adds 1 cycle.
- mem_ready asserted outside a request state is ignored.

Decomposition:
- Shared package mcpu_ctrl_define:
  - state encoding: 4-bit, 14 states
  - opcode and funct constants
  - mux select constants for RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource
- ALUOp constants come from the shared alu_define package.
- One sub-module: mcpu_alu_dec, combinational state/op/funct/rt -> ALUOp, ExtSel, ALUSrcA, decode-illegal flag.

Test Plan:
- Reset, then release with mem_ready=1, IR=ADD r3,r1,r2 (op 00, funct 20). States FETCH, DECODE, R_EXE (ALUOp=ADD, ALUSrcA=1), R_WB (RegWrite=1, RegDst=1), FETCH. Cycle-exact.
- LW with mem_ready low 3 cycles in MEM_RD. MemRead/IorD=1 held 4 cycles, MEM_WB single RegWrite=1 MemtoReg=1. Total 8 cycles.
- BNE with Zero=1 and again with Zero=0. ALUOp=BNE, PCWriteCond=1 in BRANCH both times, no RegWrite. REGIMM rt=01 gives ALUOp=BLTZ.
- SLL funct 00 gives ALUSrcA=2, ALUOp=SLL. ORI op 0D gives ExtSel=1, ALUOp=OR. LUI gives ALUOp=LU.
- JAL gives JUMP with PCWrite=1, PCSource=2, RegWrite=1, RegDst=2, MemtoReg=2. JR gives PCSource=3.
- op 3F (and funct 01) gives illegal=1, no enables ever again. rst_n=0 mid-MEM_WR kills MemWrite next edge, restart at FETCH.
